// File: rtl/popcount_pkg.sv
// popcount_pkg: shared sizing helpers for the pipelined population counter
package popcount_pkg;
  localparam int ACC_W_DEF = 16;
  function automatic int levels_f(input int in_w);
    return $clog2(in_w);
  endfunction
  function automatic int cnt_w_f(input int in_w);
    return $clog2(in_w + 1);
  endfunction
  function automatic int level_width(input int k);
    return k + 1;
  endfunction
endpackage

// File: rtl/popcount_add_stage.sv
// popcount_add_stage: one registered adder-tree level summing adjacent pairs
module popcount_add_stage
  import popcount_pkg::*;
#(
  parameter int PAIRS = 1,
  parameter int IW = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic [2*PAIRS*IW-1:0]     sum_i,
  output logic [PAIRS*(IW+1)-1:0]   sum_o
);
  logic [PAIRS*(IW+1)-1:0] sum_d, sum_q;
  for (genvar i = 0; i < PAIRS; i++) begin : g_add
    assign sum_d[i*(IW+1) +: IW+1] = {1'b0, sum_i[2*i*IW +: IW]} + {1'b0, sum_i[(2*i+1)*IW +: IW]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else if (en_i) sum_q <= sum_d;
  end
  assign sum_o = sum_q;
endmodule

// File: rtl/popcount_pipe.sv
// popcount_pipe: path-balanced pipelined popcount with valid/ready stream
// Define POPCOUNT_ACCUM_EN to add acc_clr/acc_count running-sum ports.
module popcount_pipe
  import popcount_pkg::*;
#(
  parameter int IN_W = 16,
`ifdef POPCOUNT_ACCUM_EN
  parameter int ACC_W = ACC_W_DEF,
`endif
  localparam int LEVELS = levels_f(IN_W),
  localparam int CNT_W = cnt_w_f(IN_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count
`ifdef POPCOUNT_ACCUM_EN
  ,
  input  logic              acc_clr,
  output logic [ACC_W-1:0]  acc_count
`endif
);
  localparam int PADW = 2 ** LEVELS;
  logic              en;
  logic [LEVELS-1:0] vld_q, vld_d;
  // Level k occupies the low (PADW>>k)*(k+1) bits of lvl[k]; that never exceeds PADW.
  logic [PADW-1:0]   lvl [LEVELS+1];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[LEVELS-1];
  assign lvl[0]    = PADW'(in_data);
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    logic [(PADW >> k)*level_width(k)-1:0] s;
    popcount_add_stage #(
      .PAIRS (PADW >> k),
      .IW    (level_width(k-1))
    ) u_add (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (en),
      .sum_i (lvl[k-1][(PADW >> (k-1))*level_width(k-1)-1:0]),
      .sum_o (s)
    );
    assign lvl[k] = PADW'(s);
  end
  assign out_count = lvl[LEVELS][CNT_W-1:0];
  assign vld_d = en ? LEVELS'({vld_q, in_valid}) : vld_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else vld_q <= vld_d;
  end
`ifdef POPCOUNT_ACCUM_EN
  logic             xfer;
  logic [ACC_W-1:0] acc_q, acc_d;
  assign xfer = out_valid && out_ready;
  always_comb acc_d = acc_clr ? (xfer ? ACC_W'(out_count) : '0)
                              : (xfer ? acc_q + ACC_W'(out_count) : acc_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  end
  assign acc_count = acc_q;
`endif
endmodule

// File: tb/tb_popcount_pipe.sv
// tb_popcount_pipe: randomized and directed checks against a queue-based popcount model
module tb_popcount_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [4:0]  out_count;
  logic        v13 = 1'b0;
  logic [12:0] d13 = '0;
  logic        r13, ov13;
  logic [3:0]  c13;
`ifdef POPCOUNT_ACCUM_EN
  logic        acc_clr = 1'b0;
  logic [7:0]  acc_count;
  logic [15:0] acc13;
  int          acc_m = 0;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_q[$];
  int xcyc[$];
  int e;
  bit xfer;
  bit prev_stall = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  popcount_pipe #(
    .IN_W(16)
`ifdef POPCOUNT_ACCUM_EN
    , .ACC_W(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
`ifdef POPCOUNT_ACCUM_EN
    , .acc_clr(acc_clr), .acc_count(acc_count)
`endif
  );
  popcount_pipe #(.IN_W(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(v13), .in_ready(r13), .in_data(d13),
    .out_valid(ov13), .out_ready(1'b1), .out_count(c13)
`ifdef POPCOUNT_ACCUM_EN
    , .acc_clr(1'b0), .acc_count(acc13)
`endif
  );
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    tick();
  endtask
  task automatic run13(input logic [12:0] val);
    tick();
    v13 = 1'b1;
    d13 = val;
    tick();
    v13 = 1'b0;
    repeat (3) @(negedge clk);
    check("w13_early", ov13, 0);
    @(negedge clk);
    check("w13_valid", ov13, 1);
    check("w13_count", c13, $countones(val));
  endtask
  // Scoreboard: words enter at acceptance, the head must be on the output whenever it is valid.
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      check("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) check("hold_valid", out_valid, 1);
`ifdef POPCOUNT_ACCUM_EN
      check("acc", acc_count, acc_m);
`endif
      xfer = out_valid && out_ready;
      e = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          check("count", out_count, exp_q[0]);
          if (out_ready) begin
            e = exp_q.pop_front();
            xcyc.push_back(cyc);
          end
        end
      end
`ifdef POPCOUNT_ACCUM_EN
      acc_m = acc_clr ? (xfer ? e : 0) : ((xfer ? acc_m + e : acc_m) % 256);
`endif
      if (in_valid && in_ready) exp_q.push_back($countones(in_data));
      prev_stall = out_valid && !out_ready;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int lat;
    int base;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
`ifdef POPCOUNT_ACCUM_EN
    check("rst_acc", acc_count, 0);
`endif
    #10 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    tick();
    send(16'hFFFF);
    wait_valid(lat);
    check("latency", lat, 4);
    tick();
    send(16'h0000);
    send(16'h8001);
    drain();
    base = xcyc.size();
    for (int i = 1; i <= 16; i++) send(16'((32'd1 << i) - 1));
    drain();
    check("stream_n", xcyc.size() - base, 16);
    if (xcyc.size() >= base + 16) check("stream_gap", xcyc[base+15] - xcyc[base], 15);
    out_ready = 1'b0;
    send(16'h007F);
    send(16'h00FF);
    send(16'h0FFF);
    wait_valid(lat);
    repeat (5) begin
      @(negedge clk);
      check("bp_count", out_count, 7);
      check("bp_ready", in_ready, 0);
    end
    tick();
    out_ready = 1'b1;
    drain();
    send(16'h0001);
    send(16'h0003);
    send(16'h0007);
    #2 rst_n = 1'b0;
    exp_q.delete();
`ifdef POPCOUNT_ACCUM_EN
    acc_m = 0;
`endif
    #1 check("rst_mid_valid", out_valid, 0);
    @(negedge clk);
    check("rst_mid_hold", out_valid, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_post", out_valid, 0);
    tick();
    send(16'h00FF);
    wait_valid(lat);
    check("rst_latency", lat, 4);
    tick();
    drain();
    repeat (400) begin
      tick();
      in_valid  = ($urandom % 4) != 0;
      in_data   = 16'($urandom);
      out_ready = ($urandom % 4) != 0;
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    run13(13'h1FFF);
    run13(13'h1000);
    run13(13'($urandom));
`ifdef POPCOUNT_ACCUM_EN
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    repeat (17) send(16'hFFFF);
    drain();
    @(negedge clk);
    check("acc_17", acc_count, 16);
    tick();
    out_ready = 1'b0;
    send(16'h0007);
    wait_valid(lat);
    tick();
    acc_clr   = 1'b1;
    out_ready = 1'b1;
    tick();
    acc_clr = 1'b0;
    @(negedge clk);
    check("acc_clr_xfer", acc_count, 3);
    tick();
`endif
    check("final_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
